// File: rtl/uart_sender_arbiter.sv
// uart_sender_arbiter: shares one UART number sender between several print engines.
// Sessions are granted round-robin and held until the owner drops its request.
// The owner's start/data/flags are forwarded to the sender, and sender_done is
// returned only to the owner. A watchdog forces completion of a stuck transfer.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_i                  per-requester session request (level)
//   req_start_i            per-requester one-cycle element start
//   req_data_i             packed elements, slot k = [k*DATA_W +: DATA_W]
//   req_last_col_i         per-requester "newline after element" flag
//   req_newline_only_i     per-requester "newline only" flag
//   gnt_o                  one-hot (or zero) ownership grant
//   req_done_o             one-cycle completion pulse to the owner
//   sender_data_o          element to the sender (held between starts)
//   sender_start_o         one-cycle start to the sender
//   sender_is_last_col_o   flag, valid only with sender_start_o
//   sender_newline_only_o  flag, valid only with sender_start_o
//   sender_done_i          sender completion pulse
//   busy_o                 high while a grant is held
//   timeout_o              one-cycle pulse when the watchdog fires
module uart_sender_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ-1:0]          req_start_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]          req_last_col_i,
    input  logic [NUM_REQ-1:0]          req_newline_only_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic [NUM_REQ-1:0]          req_done_o,
    output logic [DATA_W-1:0]           sender_data_o,
    output logic                        sender_start_o,
    output logic                        sender_is_last_col_o,
    output logic                        sender_newline_only_o,
    input  logic                        sender_done_i,
    output logic                        busy_o,
    output logic                        timeout_o
);

    localparam int unsigned IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        OWNED,
        SENDING
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   g;
    logic [IDX_W-1:0]   last;
    logic [WD_W-1:0]    wd;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;
    logic [DATA_W-1:0]  sel_data;

    // Round-robin pick: first requesting index after last, with wrap-around.
    // Scanning from the far end lets the nearest candidate overwrite the rest.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = int'(NUM_REQ); i >= 1; i--) begin
            cand = IDX_W'((int'(last) + i) % int'(NUM_REQ));
            if (req_i[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Owner's element slot.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (IDX_W'(k) == g) begin
                sel_data = req_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // Session FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= IDLE;
            g                     <= '0;
            last                  <= IDX_W'(NUM_REQ - 1);
            wd                    <= '0;
            gnt_o                 <= '0;
            req_done_o            <= '0;
            sender_data_o         <= '0;
            sender_start_o        <= 1'b0;
            sender_is_last_col_o  <= 1'b0;
            sender_newline_only_o <= 1'b0;
            busy_o                <= 1'b0;
            timeout_o             <= 1'b0;
        end else begin
            sender_start_o        <= 1'b0;
            sender_is_last_col_o  <= 1'b0;
            sender_newline_only_o <= 1'b0;
            req_done_o            <= '0;
            timeout_o             <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        g      <= pick_idx;
                        gnt_o  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        busy_o <= 1'b1;
                        state  <= OWNED;
                    end
                end
                OWNED: begin
                    // Release wins over a same-cycle start.
                    if (!req_i[g]) begin
                        gnt_o  <= '0;
                        busy_o <= 1'b0;
                        last   <= g;
                        state  <= IDLE;
                    end else if (req_start_i[g]) begin
                        sender_data_o         <= sel_data;
                        sender_is_last_col_o  <= req_last_col_i[g];
                        sender_newline_only_o <= req_newline_only_i[g];
                        sender_start_o        <= 1'b1;
                        wd                    <= '0;
                        state                 <= SENDING;
                    end
                end
                SENDING: begin
                    if (sender_done_i) begin
                        req_done_o <= gnt_o;
                        state      <= OWNED;
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        timeout_o  <= 1'b1;
                        req_done_o <= gnt_o;
                        state      <= OWNED;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_sender_arbiter.sv
// Self-checking bench for uart_sender_arbiter. Two instances share the stimulus:
// u_a with a long watchdog for functional tests, u_b with TIMEOUT=16 for the
// watchdog scenario. A transaction-level reference model checks random traffic.
module tb_uart_sender_arbiter;

    localparam int NR = 3;
    localparam int DW = 8;
    localparam int TA = 64;
    localparam int TBW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req, req_start, req_last_col, req_newline_only;
    logic [NR*DW-1:0] req_data;
    logic            sender_done;

    logic [NR-1:0]   a_gnt, a_req_done, b_gnt, b_req_done;
    logic [DW-1:0]   a_data, b_data;
    logic            a_start, a_lc, a_nl, a_busy, a_to;
    logic            b_start, b_lc, b_nl, b_busy, b_to;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    uart_sender_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TA)) u_a (
        .clk(clk), .rst_n(rst_n), .req_i(req), .req_start_i(req_start),
        .req_data_i(req_data), .req_last_col_i(req_last_col),
        .req_newline_only_i(req_newline_only), .gnt_o(a_gnt), .req_done_o(a_req_done),
        .sender_data_o(a_data), .sender_start_o(a_start),
        .sender_is_last_col_o(a_lc), .sender_newline_only_o(a_nl),
        .sender_done_i(sender_done), .busy_o(a_busy), .timeout_o(a_to)
    );

    uart_sender_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TBW)) u_b (
        .clk(clk), .rst_n(rst_n), .req_i(req), .req_start_i(req_start),
        .req_data_i(req_data), .req_last_col_i(req_last_col),
        .req_newline_only_i(req_newline_only), .gnt_o(b_gnt), .req_done_o(b_req_done),
        .sender_data_o(b_data), .sender_start_o(b_start),
        .sender_is_last_col_o(b_lc), .sender_newline_only_o(b_nl),
        .sender_done_i(sender_done), .busy_o(b_busy), .timeout_o(b_to)
    );

    // Reference model of u_a: who owns, whether an element is in flight,
    // and how many in-flight cycles have elapsed without completion.
    bit            model_on = 1'b0;
    int            m_owner, m_last, m_cnt;
    bit            m_sending;
    logic [NR-1:0] e_gnt, e_done;
    logic [DW-1:0] e_data;
    logic          e_start, e_lc, e_nl, e_to;

    task automatic model_reset();
        m_owner = -1; m_last = NR - 1; m_cnt = 0; m_sending = 1'b0;
        e_gnt = '0; e_done = '0; e_data = '0;
        e_start = 1'b0; e_lc = 1'b0; e_nl = 1'b0; e_to = 1'b0;
    endtask

    task automatic model_update();
        e_start = 1'b0; e_lc = 1'b0; e_nl = 1'b0; e_to = 1'b0; e_done = '0;
        if (m_owner < 0) begin
            for (int i = 1; i <= NR; i++) begin
                if (m_owner < 0 && req[(m_last + i) % NR]) m_owner = (m_last + i) % NR;
            end
            e_gnt = (m_owner < 0) ? '0 : NR'(1 << m_owner);
        end else if (!m_sending) begin
            if (!req[m_owner]) begin
                m_last = m_owner; m_owner = -1; e_gnt = '0;
            end else if (req_start[m_owner]) begin
                e_data = req_data[m_owner*DW +: DW];
                e_lc = req_last_col[m_owner]; e_nl = req_newline_only[m_owner];
                e_start = 1'b1; m_sending = 1'b1; m_cnt = 0;
            end
        end else if (sender_done) begin
            e_done = NR'(1 << m_owner); m_sending = 1'b0;
        end else begin
            m_cnt++;
            if (m_cnt == TA) begin
                e_to = 1'b1; e_done = NR'(1 << m_owner); m_sending = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (model_on) model_update();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req = '0; req_start = '0; req_data = '0;
        req_last_col = '0; req_newline_only = '0; sender_done = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({a_gnt, a_req_done, a_data, a_start, a_lc, a_nl, a_busy, a_to} !== '0) begin
            bad++; $display("FAIL reset_a: got gnt=%b done=%b data=%h start=%b busy=%b to=%b, want all 0",
                            a_gnt, a_req_done, a_data, a_start, a_busy, a_to);
        end
        total++;
        if ({b_gnt, b_req_done, b_data, b_start, b_lc, b_nl, b_busy, b_to} !== '0) begin
            bad++; $display("FAIL reset_b: got gnt=%b data=%h start=%b, want all 0", b_gnt, b_data, b_start);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if (a_gnt !== 3'b000 || a_busy !== 1'b0) begin
            bad++; $display("FAIL reset_idle: gnt=%b busy=%b want 000/0", a_gnt, a_busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 3'b001;
        tick();
        total++;
        if (a_gnt !== 3'b001 || a_busy !== 1'b1) begin
            bad++; $display("FAIL single_gnt: gnt=%b busy=%b want 001/1", a_gnt, a_busy);
        end
        req_start = 3'b001; req_data = {8'h00, 8'h00, 8'hFB}; req_last_col = 3'b001;
        tick();
        total++;
        if (a_start !== 1'b1 || a_data !== 8'hFB || a_lc !== 1'b1 || a_nl !== 1'b0) begin
            bad++; $display("FAIL single_start: start=%b data=%h lc=%b nl=%b want 1/fb/1/0",
                            a_start, a_data, a_lc, a_nl);
        end
        req_start = '0; req_last_col = '0; req_data = '0;
        tick();
        total++;
        if (a_start !== 1'b0 || a_lc !== 1'b0 || a_data !== 8'hFB) begin
            bad++; $display("FAIL single_hold: start=%b lc=%b data=%h want 0/0/fb", a_start, a_lc, a_data);
        end
        for (int i = 0; i < 38; i++) begin
            tick();
            total++;
            if (a_req_done !== 3'b000 || a_to !== 1'b0) begin
                bad++; $display("FAIL single_wait: cyc=%0d done=%b to=%b want 000/0", i, a_req_done, a_to);
            end
        end
        sender_done = 1'b1;
        tick();
        sender_done = 1'b0;
        total++;
        if (a_req_done !== 3'b001) begin
            bad++; $display("FAIL single_done: done=%b want 001", a_req_done);
        end
        tick();
        total++;
        if (a_req_done !== 3'b000) begin
            bad++; $display("FAIL single_done_pulse: done=%b want 000", a_req_done);
        end
        req = '0;
        tick();
        total++;
        if (a_gnt !== 3'b000 || a_busy !== 1'b0) begin
            bad++; $display("FAIL single_release: gnt=%b busy=%b want 000/0", a_gnt, a_busy);
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] want;
        do_reset();
        req = 3'b111;
        for (int k = 0; k < NR; k++) begin
            want = NR'(1 << k);
            tick();
            total++;
            if (a_gnt !== want) begin
                bad++; $display("FAIL rr_order: step=%0d gnt=%b want %b", k, a_gnt, want);
            end
            req_start = want; req_data = {3{DW'(k + 1)}};
            tick();
            req_start = '0;
            sender_done = 1'b1;
            tick();
            sender_done = 1'b0;
            total++;
            if (a_req_done !== want) begin
                bad++; $display("FAIL rr_done: step=%0d done=%b want %b", k, a_req_done, want);
            end
            req = req & ~want;
            tick();
            total++;
            if (a_gnt !== 3'b000) begin
                bad++; $display("FAIL rr_idle_gap: step=%0d gnt=%b want 000", k, a_gnt);
            end
        end
        req = 3'b111;
        tick();
        total++;
        if (a_gnt !== 3'b001) begin
            bad++; $display("FAIL rr_wrap: gnt=%b want 001", a_gnt);
        end
        req = '0;
        tick();
    endtask

    task automatic test_isolation();
        do_reset();
        req = 3'b010;
        tick();
        total++;
        if (a_gnt !== 3'b010) begin
            bad++; $display("FAIL iso_gnt: gnt=%b want 010", a_gnt);
        end
        req_start = 3'b010; req_data = {8'd0, 8'd7, 8'd0};
        tick();
        req_start = '0;
        tick();
        req_start = 3'b101; req_data = {8'd99, 8'd55, 8'd99};
        tick();
        req_start = '0;
        total++;
        if (a_start !== 1'b0 || a_data !== 8'd7) begin
            bad++; $display("FAIL iso_ignore: start=%b data=%0d want 0/7", a_start, a_data);
        end
        sender_done = 1'b1;
        tick();
        sender_done = 1'b0;
        total++;
        if (a_req_done !== 3'b010 || a_data !== 8'd7) begin
            bad++; $display("FAIL iso_done: done=%b data=%0d want 010/7", a_req_done, a_data);
        end
        req = '0;
        tick();
    endtask

    task automatic test_watchdog();
        int early;
        do_reset();
        req = 3'b001;
        tick();
        req_start = 3'b001; req_data = {8'd0, 8'd0, 8'h5A};
        tick();
        req_start = '0;
        total++;
        if (b_start !== 1'b1 || b_data !== 8'h5A) begin
            bad++; $display("FAIL wd_start: start=%b data=%h want 1/5a", b_start, b_data);
        end
        early = 0;
        for (int i = 1; i < TBW; i++) begin
            tick();
            if (b_to !== 1'b0 || b_req_done !== 3'b000) early++;
        end
        total++;
        if (early != 0) begin
            bad++; $display("FAIL wd_early: early_cycles=%0d want 0", early);
        end
        tick();
        total++;
        if (b_to !== 1'b1 || b_req_done !== 3'b001 || a_to !== 1'b0) begin
            bad++; $display("FAIL wd_fire: b_to=%b b_done=%b a_to=%b want 1/001/0", b_to, b_req_done, a_to);
        end
        tick();
        total++;
        if (b_to !== 1'b0 || b_req_done !== 3'b000) begin
            bad++; $display("FAIL wd_pulse: b_to=%b b_done=%b want 0/000", b_to, b_req_done);
        end
        sender_done = 1'b1;
        tick();
        sender_done = 1'b0;
        total++;
        if (b_req_done !== 3'b000 || a_req_done !== 3'b001) begin
            bad++; $display("FAIL wd_late_done: b_done=%b a_done=%b want 000/001", b_req_done, a_req_done);
        end
        req_start = 3'b001; req_data = {8'd0, 8'd0, 8'h3C};
        tick();
        req_start = '0;
        total++;
        if (b_start !== 1'b1 || b_data !== 8'h3C || a_start !== 1'b1) begin
            bad++; $display("FAIL wd_owned: b_start=%b b_data=%h a_start=%b want 1/3c/1", b_start, b_data, a_start);
        end
        req = '0;
        tick();
    endtask

    task automatic test_release_sending();
        do_reset();
        req = 3'b001;
        tick();
        req_start = 3'b001; req_data = {8'd0, 8'd0, 8'h11};
        tick();
        req_start = '0;
        tick();
        req = '0;
        tick();
        total++;
        if (a_gnt !== 3'b001) begin
            bad++; $display("FAIL rel_hold: gnt=%b want 001", a_gnt);
        end
        tick();
        sender_done = 1'b1;
        tick();
        sender_done = 1'b0;
        total++;
        if (a_req_done !== 3'b001 || a_gnt !== 3'b001) begin
            bad++; $display("FAIL rel_done: done=%b gnt=%b want 001/001", a_req_done, a_gnt);
        end
        tick();
        total++;
        if (a_gnt !== 3'b000 || a_busy !== 1'b0) begin
            bad++; $display("FAIL rel_clear: gnt=%b busy=%b want 000/0", a_gnt, a_busy);
        end
    endtask

    task automatic test_reset_mid();
        int refire;
        do_reset();
        req = 3'b001;
        tick();
        req_start = 3'b001; req_data = {8'd0, 8'd0, 8'h77}; req_newline_only = 3'b001;
        tick();
        req_start = '0; req_newline_only = '0;
        total++;
        if (a_start !== 1'b1 || a_nl !== 1'b1) begin
            bad++; $display("FAIL mid_start: start=%b nl=%b want 1/1", a_start, a_nl);
        end
        rst_n = 1'b0;
        req = 3'b010;
        #1;
        total++;
        if ({a_gnt, a_req_done, a_data, a_start, a_lc, a_nl, a_busy, a_to} !== '0) begin
            bad++; $display("FAIL mid_async: gnt=%b data=%h start=%b nl=%b busy=%b want all 0",
                            a_gnt, a_data, a_start, a_nl, a_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if (a_gnt !== 3'b010) begin
            bad++; $display("FAIL mid_regrant: gnt=%b want 010", a_gnt);
        end
        refire = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (a_start !== 1'b0) refire++;
        end
        total++;
        if (refire != 0) begin
            bad++; $display("FAIL mid_refire: starts=%0d want 0", refire);
        end
        req = '0;
        tick();
    endtask

    task automatic test_random();
        int done_pct;
        do_reset();
        model_on = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            done_pct = ((c / 400) % 2 == 0) ? 15 : 0;
            for (int k = 0; k < NR; k++) begin
                if ($urandom_range(0, 15) == 0) req[k] = ~req[k];
                req_start[k] = ($urandom_range(0, 3) == 0);
                req_last_col[k] = $urandom_range(0, 1) == 1;
                req_newline_only[k] = $urandom_range(0, 1) == 1;
            end
            req_data = NR*DW'($urandom);
            sender_done = ($urandom_range(0, 99) < done_pct);
            tick();
            total++;
            if (a_gnt !== e_gnt || a_req_done !== e_done || a_busy !== (e_gnt != '0) || a_to !== e_to) begin
                bad++; $display("FAIL rand_ctrl: cyc=%0d gnt=%b/%b done=%b/%b busy=%b to=%b/%b (got/want)",
                                c, a_gnt, e_gnt, a_req_done, e_done, a_busy, a_to, e_to);
            end
            total++;
            if (a_start !== e_start || a_data !== e_data || a_lc !== e_lc || a_nl !== e_nl) begin
                bad++; $display("FAIL rand_send: cyc=%0d start=%b/%b data=%h/%h lc=%b/%b nl=%b/%b (got/want)",
                                c, a_start, e_start, a_data, e_data, a_lc, e_lc, a_nl, e_nl);
            end
        end
        model_on = 1'b0;
        clear_inputs();
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_isolation();
        test_watchdog();
        test_release_sending();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
